program_launcher: RTL and testbench

- Host-side sequencer that drives the processor core's start/start_addr/done handshake from the launching end.
- Holds a small table of program entry addresses and runs them back to back, one after another.
- For each program it pulses start with the entry address, then waits for the core's done.
- It reports the cycle count for each program and flags timeouts; it sits beside the core in the test/system wrapper.

---
 rtl/launcher_pkg.sv | 21 ++
 rtl/launch_table.sv | 30 +++
 rtl/program_launcher.sv | 189 ++++++++++++++++++
 tb/tb_program_launcher.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/launcher_pkg.sv
// Shared types and helpers for the program launcher.
package launcher_pkg;

  localparam int unsigned CYCLE_W = 16;
  localparam int unsigned ADDR_W  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ARM    = 3'd2,
    RUN    = 3'd3,
    REPORT = 3'd4,
    FINISH = 3'd5
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    return (v == '1) ? v : v + CYCLE_W'(1);
  endfunction

endpackage

// File: rtl/launch_table.sv
// Program entry address table: one write port, one combinational read port.
module launch_table
  import launcher_pkg::*;
#(
  parameter int unsigned NUM_PROGS = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [ADDR_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [ADDR_W-1:0] rd_data_o
);

  logic [ADDR_W-1:0] mem_q [NUM_PROGS];

  // Entry storage; out-of-range write indices are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PROGS; i++) mem_q[i] <= '0;
    end else if (we_i && (32'(wr_idx_i) < NUM_PROGS)) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/program_launcher.sv
// Host-side sequencer: launches table entries on the core one after another,
// times each run until done rises, and reports cycles / timeouts.
module program_launcher
  import launcher_pkg::*;
#(
  parameter int unsigned NUM_PROGS    = 4,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 4096,
  localparam int unsigned IDX_W       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  localparam int unsigned CNT_W       = IDX_W + 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               tbl_we,
  input  logic [IDX_W-1:0]   tbl_idx,
  input  logic [ADDR_W-1:0]  tbl_addr,
  input  logic               go,
  input  logic [CNT_W-1:0]   prog_count,
  input  logic               done,
  output logic               start,
  output logic [ADDR_W-1:0]  start_addr,
  output logic               busy,
  output logic               result_valid,
  output logic [IDX_W-1:0]   result_idx,
  output logic [CYCLE_W-1:0] result_cycles,
  output logic               timeout_err,
  output logic               all_done
);

  localparam int unsigned HOLD_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CYCLE_W-1:0]  cyc_q, cyc_d;
  logic                done_prev_q;
  logic                terr_q, terr_d;

  logic                start_q, start_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic                busy_q, busy_d;
  logic                rv_q, rv_d;
  logic [IDX_W-1:0]    ridx_q, ridx_d;
  logic [CYCLE_W-1:0]  rcyc_q, rcyc_d;
  logic                all_done_q, all_done_d;

  logic [ADDR_W-1:0]   tbl_rd_data;

  launch_table #(
    .NUM_PROGS (NUM_PROGS),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk       (CLK),
    .rst_n     (RST_N),
    .we_i      (tbl_we && (state_q == IDLE)),
    .wr_idx_i  (tbl_idx),
    .wr_data_i (tbl_addr),
    .rd_idx_i  (idx_d),
    .rd_data_o (tbl_rd_data)
  );

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    cyc_d      = cyc_q;
    terr_d     = terr_q;
    start_d    = 1'b0;
    busy_d     = 1'b0;
    rv_d       = 1'b0;
    ridx_d     = ridx_q;
    rcyc_d     = rcyc_q;
    all_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          if (prog_count == '0) begin
            all_done_d = 1'b1;
          end else begin
            cnt_d   = (prog_count > CNT_W'(NUM_PROGS)) ? CNT_W'(NUM_PROGS) : prog_count;
            idx_d   = '0;
            hold_d  = '0;
            terr_d  = 1'b0;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (hold_q == HOLD_W'(START_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = ARM;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ARM: begin
        // A done left high from earlier activity must clear before arming.
        cyc_d = sat_inc(cyc_q);
        if (!done) state_d = RUN;
      end
      RUN: begin
        if (done && !done_prev_q) begin
          state_d = REPORT;
        end else if (cyc_q >= CYCLE_W'(TIMEOUT)) begin
          terr_d  = 1'b1;
          state_d = REPORT;
        end else begin
          cyc_d = sat_inc(cyc_q);
        end
      end
      REPORT: begin
        if (CNT_W'(idx_q) == cnt_q - CNT_W'(1)) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          hold_d  = '0;
          state_d = LAUNCH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    start_d = (state_d == LAUNCH);
    busy_d  = (state_d != IDLE) && (state_d != FINISH);
    if (state_d == REPORT) begin
      rv_d   = 1'b1;
      ridx_d = idx_q;
      rcyc_d = cyc_q;
    end
    if (state_d == FINISH) all_done_d = 1'b1;
  end

  // start_addr follows the table only while launching, otherwise holds.
  assign start_addr_d = (state_d == LAUNCH) ? tbl_rd_data : start_addr_q;

  // State, counters and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      cyc_q        <= '0;
      done_prev_q  <= 1'b0;
      terr_q       <= 1'b0;
      start_q      <= 1'b0;
      start_addr_q <= '0;
      busy_q       <= 1'b0;
      rv_q         <= 1'b0;
      ridx_q       <= '0;
      rcyc_q       <= '0;
      all_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      cyc_q        <= cyc_d;
      done_prev_q  <= done;
      terr_q       <= terr_d;
      start_q      <= start_d;
      start_addr_q <= start_addr_d;
      busy_q       <= busy_d;
      rv_q         <= rv_d;
      ridx_q       <= ridx_d;
      rcyc_q       <= rcyc_d;
      all_done_q   <= all_done_d;
    end
  end

  assign start         = start_q;
  assign start_addr    = start_addr_q;
  assign busy          = busy_q;
  assign result_valid  = rv_q;
  assign result_idx    = ridx_q;
  assign result_cycles = rcyc_q;
  assign timeout_err   = terr_q;
  assign all_done      = all_done_q;

endmodule

// File: tb/tb_program_launcher.sv
// Bench for program_launcher: table-driven runs, reset/write corner cases,
// and randomized runs checked against a per-program outcome model.
module tb_program_launcher;

  localparam int unsigned NP = 4;
  localparam int unsigned SC = 2;
  localparam int unsigned TO = 50;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        tbl_we = 1'b0;
  logic [1:0]  tbl_idx = '0;
  logic [7:0]  tbl_addr = '0;
  logic        go = 1'b0;
  logic [2:0]  prog_count = '0;
  logic        done = 1'b0;
  logic        start;
  logic [7:0]  start_addr;
  logic        busy;
  logic        result_valid;
  logic [1:0]  result_idx;
  logic [15:0] result_cycles;
  logic        timeout_err;
  logic        all_done;

  program_launcher #(
    .NUM_PROGS    (NP),
    .START_CYCLES (SC),
    .TIMEOUT      (TO)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .tbl_we        (tbl_we),
    .tbl_idx       (tbl_idx),
    .tbl_addr      (tbl_addr),
    .go            (go),
    .prog_count    (prog_count),
    .done          (done),
    .start         (start),
    .start_addr    (start_addr),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_idx    (result_idx),
    .result_cycles (result_cycles),
    .timeout_err   (timeout_err),
    .all_done      (all_done)
  );

  always #5 CLK = ~CLK;

  // Per-program core behaviour: done high for 'pre' cycles after start
  // falls, then low, then rising at cycle 'rise' (unless 'never').
  typedef struct {
    int unsigned pre;
    int unsigned rise;
    bit          never;
    int unsigned exp_cyc;
    bit          exp_to;
  } scen_t;

  typedef struct {
    int unsigned pc;
    int unsigned pre;
    int unsigned rise;
    bit          never;
    bit          inj;
    int unsigned exp_cyc;
    bit          exp_to;
  } vec_t;

  scen_t      sc [NP];
  logic [7:0] mdl [NP];
  bit         terr_exp = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Outcome of one program from its scenario alone.
  function automatic scen_t mk_scen(input int unsigned pre, input int unsigned rise, input bit never);
    scen_t s;
    s.pre    = pre;
    s.rise   = rise;
    s.never  = never;
    s.exp_to = never || (rise > TO);
    s.exp_cyc = s.exp_to ? TO : rise;
    return s;
  endfunction

  function automatic logic core_done(input int unsigned prog, input int k);
    if (prog >= NP) return 1'b0;
    if (k < 0) return sc[prog].pre > 0;
    if (k < int'(sc[prog].pre)) return 1'b1;
    if (!sc[prog].never && k >= int'(sc[prog].rise)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wr_tbl(input int unsigned idx, input logic [7:0] addr);
    tbl_we = 1'b1;
    tbl_idx = 2'(idx);
    tbl_addr = addr;
    step();
    tbl_we = 1'b0;
    mdl[idx] = addr;
  endtask

  // One go: drive the core model cycle by cycle and check every event.
  task automatic run_seq(input int unsigned pc, input bit inj);
    int unsigned n_eff, prog, got, launches, start_run;
    int k;
    bit prev_start, fin;
    n_eff = (pc > NP) ? NP : pc;
    if (n_eff > 0) terr_exp = 1'b0;
    go = 1'b1;
    prog_count = 3'(pc);
    done = core_done(0, -1) && (n_eff > 0);
    prog = 0; got = 0; launches = 0; start_run = 0; k = -1;
    prev_start = 1'b0; fin = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      step();
      go = 1'b0;
      tbl_we = 1'b0;
      if (cyc == 0) begin
        chk("busy_after_go", 32'(busy), 32'(n_eff > 0));
        if (n_eff == 0) chk("zero_go_alldone", 32'(all_done), 32'd1);
      end
      if (inj && cyc == 1) begin
        tbl_we = 1'b1;
        tbl_idx = 2'd1;
        tbl_addr = 8'hFF;
      end
      if (start) begin
        if (start_run == 0) begin
          chk("start_addr", 32'(start_addr), 32'(mdl[prog % NP]));
          launches++;
        end
        start_run++;
        k = -1;
      end else if (prev_start) begin
        chk("start_len", start_run, SC);
        start_run = 0;
        k = 0;
      end else if (k >= 0) begin
        k++;
      end
      prev_start = start;
      if (result_valid) begin
        if (prog < n_eff) begin
          terr_exp = terr_exp | sc[prog].exp_to;
          chk("result_idx", 32'(result_idx), prog);
          chk("result_cycles", 32'(result_cycles), sc[prog].exp_cyc);
        end
        prog++;
        got++;
        k = -1;
      end
      chk("timeout_err", 32'(timeout_err), 32'(terr_exp));
      if (all_done) begin
        chk("result_count", got, n_eff);
        chk("launch_count", launches, n_eff);
        chk("busy_at_alldone", 32'(busy), 32'd0);
        fin = 1'b1;
      end
      done = core_done(prog, k);
    end
    if (!fin) chk("seq_budget", 32'd0, 32'd1);
    step();
    chk("post_alldone_quiet", {29'd0, all_done, busy, start}, 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return {1'b0, start, start_addr, busy, result_valid, result_idx,
            result_cycles, timeout_err, all_done};
  endfunction

  vec_t vecs [9];

  initial begin
    bit ok;
    vecs[0] = '{2, 0, 10, 0, 0, 10, 0};
    vecs[1] = '{1, 3,  8, 0, 0,  8, 0};
    vecs[2] = '{2, 0,  0, 1, 0, 50, 1};
    vecs[3] = '{3, 0, 50, 0, 0, 50, 0};
    vecs[4] = '{4, 0, 51, 0, 0, 50, 1};
    vecs[5] = '{0, 0, 10, 0, 0, 10, 0};
    vecs[6] = '{7, 0,  1, 0, 0,  1, 0};
    vecs[7] = '{2, 0,  5, 0, 1,  5, 0};
    vecs[8] = '{2, 2, 20, 0, 0, 20, 0};
    for (int i = 0; i < int'(NP); i++) mdl[i] = 8'h00;

    #3;
    chk("reset_outputs", all_outs(), 32'd0);
    repeat (2) step();
    RST_N = 1'b1;
    step();
    chk("idle_after_reset", all_outs(), 32'd0);

    wr_tbl(0, 8'h00);
    wr_tbl(1, 8'h20);
    wr_tbl(2, 8'h40);
    wr_tbl(3, 8'h60);

    for (int v = 0; v < 9; v++) begin
      for (int p = 0; p < int'(NP); p++) sc[p] = '{vecs[v].pre, vecs[v].rise, vecs[v].never,
                                                   vecs[v].exp_cyc, vecs[v].exp_to};
      run_seq(vecs[v].pc, vecs[v].inj);
    end

    // Reset during RUN of program 1.
    for (int p = 0; p < int'(NP); p++) sc[p] = mk_scen(0, 0, 1'b1);
    go = 1'b1; prog_count = 3'd2; done = 1'b0;
    step();
    go = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin step(); ok = result_valid; end
    chk("rst_reach_report", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin step(); ok = start; end
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin step(); ok = !start; end
    repeat (5) step();
    chk("rst_busy_before", 32'(busy), 32'd1);
    #2 RST_N = 1'b0;
    #1 chk("rst_async_outputs", all_outs(), 32'd0);
    step();
    chk("rst_held_outputs", all_outs(), 32'd0);
    RST_N = 1'b1;
    for (int i = 0; i < int'(NP); i++) mdl[i] = 8'h00;
    terr_exp = 1'b0;
    step();
    for (int p = 0; p < int'(NP); p++) sc[p] = mk_scen(0, 10, 1'b0);
    run_seq(2, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < int'(NP); i++) wr_tbl(i, 8'($urandom));
      for (int p = 0; p < int'(NP); p++) begin
        int unsigned pre;
        pre = $urandom_range(0, 3);
        sc[p] = mk_scen(pre, $urandom_range(pre + 1, 60), ($urandom_range(0, 5) == 0));
      end
      run_seq($urandom_range(0, 7), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
